// File: rtl/uart_tx_framer_pkg.sv
// Shared UART constants and frame-state encoding; the receiver imports the same
// package so both directions agree on timing and legal frame lengths.
package uart_tx_framer_pkg;

  localparam int CLKS_PER_BIT_DEF = 32;
  localparam int FRAME_LEN_MIN    = 5;
  localparam int FRAME_LEN_MAX    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Out-of-range lengths fall back to a full byte rather than a malformed frame.
  function automatic logic [3:0] legal_frame_len(input logic [3:0] len);
    return ((len < 4'(FRAME_LEN_MIN)) || (len > 4'(FRAME_LEN_MAX)))
           ? 4'(FRAME_LEN_MAX) : len;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// clr restarts the period so every bit state gets a full CLKS_PER_BIT cycles.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Driven from the registered count only; clr is derived from tick upstream.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, LSB-first data (5..8 bits), optional even parity, one stop.
// Frame format is captured at the handshake so register writes mid-frame only affect the next one.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_en,
  input  logic [3:0]        frame_len,
  output logic              Tx,
  output logic              busy,
  output logic [2:0]        debug_state
);

  localparam int BW = $clog2(DATA_W);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_len;
  logic              r_par_en;
  logic              r_par;
  logic [BW-1:0]     r_bit_cnt;

  logic w_accept;
  logic w_tick;
  logic w_baud_clr;
  logic w_last_bit;

  assign tx_ready    = (r_state == ST_IDLE) & ~rst;
  assign w_accept    = tx_valid & tx_ready;
  assign w_last_bit  = (r_bit_cnt == BW'(r_len - 4'd1));
  assign busy        = (r_state != ST_IDLE);
  assign debug_state = r_state;

  // Hold the timer at zero in IDLE and restart it on every state change.
  assign w_baud_clr  = (r_state == ST_IDLE) | (w_state_nxt != r_state);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_baud_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Tx          = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_START;
      end
      ST_START: begin
        Tx = 1'b0;
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        Tx = r_shift[0];
        if (w_tick && w_last_bit) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        Tx = r_par;
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Parity accumulates over the bits actually shifted out, so short frames
  // never pick up the unsent upper bits of the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_len     <= 4'(FRAME_LEN_MAX);
      r_par_en  <= 1'b0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= tx_data;
      r_len     <= legal_frame_len(frame_len);
      r_par_en  <= parity_en;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end else if ((r_state == ST_DATA) && w_tick) begin
      r_shift <= r_shift >> 1;
      r_par   <= r_par ^ r_shift[0];
      if (!w_last_bit) r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboarded bench for uart_tx_framer: expected frames are queued at drive time
// and compared against the sampled Tx line, debug_state and frame duration.
module tb_uart_tx_framer;

  localparam int CPB = 32;
  localparam int TO  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       parity_en = 1'b0;
  logic [3:0] frame_len = 4'd8;
  logic       Tx;
  logic       busy;
  logic [2:0] debug_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] bits;
    logic [47:0] sts;
    int          nbits;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_en   (parity_en),
    .frame_len   (frame_len),
    .Tx          (Tx),
    .busy        (busy),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: line levels per bit, state code per bit, total length.
  function automatic exp_t model(input logic [7:0] d, input logic p, input logic [3:0] fl);
    exp_t e;
    int   l;
    int   k;
    logic par;
    l = (fl >= 4'd5 && fl <= 4'd8) ? int'(fl) : 8;
    e.bits = '0;
    e.sts  = '0;
    k      = 0;
    par    = 1'b0;
    e.bits[k] = 1'b0; e.sts[3*k +: 3] = 3'd1; k++;
    for (int i = 0; i < l; i++) begin
      e.bits[k] = d[i]; e.sts[3*k +: 3] = 3'd2; par ^= d[i]; k++;
    end
    if (p) begin
      e.bits[k] = par; e.sts[3*k +: 3] = 3'd3; k++;
    end
    e.bits[k] = 1'b1; e.sts[3*k +: 3] = 3'd4; k++;
    e.nbits  = k;
    e.cycles = k * CPB;
    return e;
  endfunction

  // Offers one byte, waits for the handshake, then scrambles the inputs so any
  // use of unlatched values shows up in the frame.
  task automatic drive(input logic [7:0] d, input logic p, input logic [3:0] fl, input bit push);
    int k;
    @(negedge clk);
    tx_data   = d;
    parity_en = p;
    frame_len = fl;
    tx_valid  = 1'b1;
    if (push) sb.push_back(model(d, p, fl));
    k = 0;
    while (tx_ready !== 1'b1 && k < TO) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", 64'(k >= TO), 64'd0);
    @(posedge clk);
    #1;
    tx_valid  = 1'b0;
    tx_data   = 8'($urandom);
    parity_en = ~p;
    frame_len = 4'($urandom);
  endtask

  task automatic rx_frame(input string tag, output int gap);
    exp_t        e;
    logic [15:0] got_bits;
    logic [47:0] got_sts;
    int          k;
    int          t0;
    got_bits = '0;
    got_sts  = '0;
    k = 0;
    while (Tx !== 1'b0 && k < TO) begin
      @(negedge clk);
      k++;
    end
    gap = k;
    check({tag, " start_timeout"}, 64'(k >= TO), 64'd0);
    if (k >= TO) return;
    check({tag, " sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < e.nbits; i++) begin
      got_bits[i]        = Tx;
      got_sts[3*i +: 3]  = debug_state;
      if (i == 0) check({tag, " busy_start"}, {63'd0, busy}, 64'd1);
      if (i < e.nbits - 1) repeat (CPB) @(negedge clk);
    end
    k = 0;
    while (tx_ready !== 1'b1 && k < TO) begin
      @(negedge clk);
      k++;
    end
    check({tag, " bits"},    64'(got_bits), 64'(e.bits));
    check({tag, " states"},  64'(got_sts),  64'(e.sts));
    check({tag, " cycles"},  64'(cyc - t0), 64'(e.cycles));
    check({tag, " idle_tx"}, {62'd0, Tx, busy}, 64'b10);
  endtask

  task automatic back_to_back();
    int g0;
    int g1;
    int k;
    fork
      begin
        @(negedge clk);
        tx_data   = 8'h9F;
        parity_en = 1'b1;
        frame_len = 4'd8;
        tx_valid  = 1'b1;
        sb.push_back(model(8'h9F, 1'b1, 4'd8));
        k = 0;
        while (tx_ready !== 1'b1 && k < TO) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1;
        tx_data   = 8'h91;
        parity_en = 1'b0;
        sb.push_back(model(8'h91, 1'b0, 4'd8));
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (tx_ready !== 1'b1 && k < TO);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
      end
      begin
        rx_frame("b2b_9F", g0);
        rx_frame("b2b_91", g1);
        check("b2b_gap", 64'(g1), 64'd1);
      end
    join
  endtask

  initial begin
    int         g;
    logic [7:0] d;
    logic       p;
    logic [3:0] fl;

    // Reset: valid is offered but must not be taken.
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {58'd0, Tx, busy, tx_ready, debug_state}, 64'b100000);
    tx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, tx_ready}, 64'd1);

    drive(8'h90, 1'b0, 4'd8, 1'b1);  rx_frame("p0_l8_90", g);
    drive(8'hCF, 1'b1, 4'd8, 1'b1);  rx_frame("p1_l8_CF", g);
    drive(8'h07, 1'b1, 4'd8, 1'b1);  rx_frame("p1_l8_07", g);
    drive(8'hFF, 1'b1, 4'd5, 1'b1);  rx_frame("p1_l5_FF", g);
    drive(8'hA6, 1'b0, 4'd12, 1'b1); rx_frame("p0_l12_A6", g);
    drive(8'h5A, 1'b1, 4'd6, 1'b1);  rx_frame("p1_l6_5A", g);
    drive(8'h33, 1'b0, 4'd3, 1'b1);  rx_frame("p0_l3_33", g);

    back_to_back();

    // Reset mid-DATA while Tx is low (bit 1 of 0xA5 is 0).
    drive(8'hA5, 1'b1, 4'd8, 1'b0);
    repeat (CPB * 3) @(negedge clk);
    check("mid_state", {61'd0, debug_state, Tx}, {60'd0, 3'd2, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {58'd0, Tx, busy, tx_ready, debug_state}, 64'b100000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release", {62'd0, tx_ready, Tx}, 64'b11);
    drive(8'h3C, 1'b1, 4'd7, 1'b1);  rx_frame("after_rst_3C", g);

    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom);
      fl = 4'($urandom_range(0, 15));
      drive(d, p, fl, 1'b1);
      rx_frame("random", g);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- UART transmitter that serialises response bytes (register read-backs from the address decoder) onto the Tx line.
- Frame format is set by the same parity and frame_length registers the receiver uses, so both ends agree.
- Sits between the register/decoder block (byte source, valid/ready) and the board Tx pin.
- Frame: start bit (0), LSB-first data, optional even parity, one stop bit (1).

Parameters:
CLKS_PER_BIT, 32, clock cycles per bit (320 ns per bit at a 10 ns clk)
DATA_W, 8, maximum data bits per frame

Ports:
clk  in  1  system clock; one clock domain, all logic on the rising edge
rst  in  1  synchronous, active-high reset
tx_data  in  8  byte to send; bit 0 goes first
tx_valid  in  1  source has a byte ready
tx_ready  out  1  block can accept a byte; transfer happens when tx_valid & tx_ready
parity_en  in  1  from parity register; 1 = append even-parity bit
frame_len  in  4  from frame_length register; number of data bits, legal 5..8
Tx  out  1  serial line, idles high
busy  out  1  a frame is in progress
debug_state  out  3  current FSM state encoding, for the top-level debug mux

Behaviour:
- Reset (rst high at a clock edge):
  - Tx=1, busy=0, state=IDLE, bit and baud counters cleared.
  - tx_ready=0 while rst is high.
  - Reset mid-frame aborts the frame at once; Tx returns to 1 on the next edge.
- tx_ready = (state==IDLE) & ~rst. It is combinational from registered state.
- On acceptance (tx_valid & tx_ready at edge N), latch tx_data, parity_en and frame_len:
  - frame_len outside 5..8 is latched as 8.
  - The latched copies are used for the whole frame. Register changes mid-frame take effect on the next frame only.
- Start bit: from edge N, Tx=0; busy=1 from edge N.
- FSM: IDLE -> START -> DATA -> (PARITY if parity_en latched) -> STOP -> IDLE.
- Each bit state holds Tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1, resets on every state change, and produces a one-cycle tick on its terminal count.
- DATA: shifts out latched bits 0..len-1. The bit counter advances on each tick; leave DATA when counter==len-1 at the tick.
- PARITY: Tx = XOR of the len data bits actually sent, i.e. even parity (total ones including parity bit is even).
- STOP: Tx=1 for CLKS_PER_BIT cycles. At its tick go to IDLE with busy=0; tx_ready rises that same edge.
- Frame length: (2 + len + parity_en) * CLKS_PER_BIT cycles from edge N to return to IDLE.
- Back-to-back: if tx_valid is held, the next accept happens in the first IDLE cycle. Exactly one IDLE cycle (Tx=1) separates consecutive frames.
- tx_valid while busy: ignored; not an error. The source must hold data stable until the handshake.
- tx_data is not inspected outside the accept cycle.
- Bit counter: 3 bits; baud counter: clog2(CLKS_PER_BIT) bits. No counter may wrap inside a legal frame.
- debug_state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings (IDLE..STOP);
  - default CLKS_PER_BIT=32;
  - FRAME_LEN_MIN=5 and FRAME_LEN_MAX=8.
- The receiver includes the same header so both directions agree on the constants.
- One sub-module, uart_baud_gen:
  - inputs clk, rst, clr; output tick;
  - parameter CLKS_PER_BIT;
  - reusable by the receiver in a later refactor.
- The FSM, shift register and parity logic stay in uart_tx_framer.

Test Plan:
- Parity off, len 8, send 0x90 -> Tx low 320 ns, then data 0,0,0,0,1,0,0,1 at 320 ns each, stop high. tx_ready returns 320 cycles after accept.
- Parity on, len 8, send 0xCF -> data 1,1,1,1,0,0,1,1, parity 0, stop 1; 352 cycles. Send 0x07 -> parity bit 1.
- Parity on, len 5, send 0xFF -> five 1 data bits, parity 1, stop; 256 cycles. len=12 -> treated as 8.
- tx_valid held high with 0x9F then 0x91 -> two frames separated by exactly one Tx-high cycle. parity_en toggled mid-frame 1 -> frame 1 unchanged, frame 2 uses the new setting.
- rst pulsed one cycle in mid DATA -> Tx=1, busy=0 next edge; tx_ready=1 the cycle after rst drops; next frame is clean.
- Loopback into the existing receiver/decoder top: sending 0x91 then 0x9F via the framer drives the receiver's debug_frame/debug_reg as expected, with no parity error.
